mdu_hilo: RTL and testbench

- Multiply/divide unit in the EX stage; owns the HI/LO architectural registers.
- Writeback selection reads hi/lo as two of its sources; this block is the producer side.
- Executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo immediately.
- Drives busy so the hazard unit can stall later HI/LO accesses and MDU starts.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_hilo_if.sv | 20 ++
 rtl/mdu_calc.sv | 72 +++++++
 rtl/mdu_hilo.sv | 96 +++++++++
 tb/tb_mdu_hilo.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// control state encoding and the iteration counter width.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_RSVD  = 3'b111
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int CNT_W = 4;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg32_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_hilo_if;
    logic        start;
    logic [2:0]  MDUop;
    logic [31:0] D1;
    logic [31:0] D2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output start, MDUop, D1, D2,
        input  hi, lo, busy
    );

    modport slave (
        input  start, MDUop, D1, D2,
        output hi, lo, busy
    );
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit result for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow conventions. Result packs {hi, lo}.
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic [63:0] result
);

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [31:0] divisor_safe_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] mag_q_s;
    logic [31:0] mag_r_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic        div_zero_s;
    logic        div_ovf_s;

    assign prod_signed_s   = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    assign prod_unsigned_s = {32'd0, D1} * {32'd0, D2};

    // A zero divisor is replaced so the dividers never see it; the result is overridden below.
    assign div_zero_s     = (D2 == 32'd0);
    assign div_ovf_s      = (D1 == 32'h8000_0000) && (D2 == 32'hFFFF_FFFF);
    assign divisor_safe_s = div_zero_s ? 32'd1 : D2;

    assign uq_s = D1 / divisor_safe_s;
    assign ur_s = D1 % divisor_safe_s;

    assign mag_a_s = abs32(D1);
    assign mag_b_s = div_zero_s ? 32'd1 : abs32(D2);
    assign mag_q_s = mag_a_s / mag_b_s;
    assign mag_r_s = mag_a_s % mag_b_s;

    // Truncating division: quotient sign from operand signs, remainder follows the dividend.
    assign sq_s = neg32_if(D1[31] ^ D2[31], mag_q_s);
    assign sr_s = neg32_if(D1[31], mag_r_s);

    // Result selection per operation
    always_comb begin
        result = 64'd0;
        case (op)
            MDU_MULT:  result = prod_signed_s;
            MDU_MULTU: result = prod_unsigned_s;
            MDU_DIV: begin
                if (div_zero_s) begin
                    result = {D1, 32'hFFFF_FFFF};
                end else if (div_ovf_s) begin
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {sr_s, sq_s};
                end
            end
            MDU_DIVU: begin
                if (div_zero_s) begin
                    result = {D1, 32'hFFFF_FFFF};
                end else begin
                    result = {ur_s, uq_s};
                end
            end
            default:   result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning HI/LO: stages a result, holds busy for a fixed
// latency, then commits. mthi/mtlo write immediately when idle.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic          clk,
    input  logic          reset,
    mdu_hilo_if.slave     bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_op_e          op_s;
    logic [63:0]      calc_s;
    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      hi_n_r;
    logic [31:0]      lo_n_r;

    assign op_s = mdu_op_e'(bus.MDUop);

    mdu_calc u_calc (
        .op     (op_s),
        .D1     (bus.D1),
        .D2     (bus.D2),
        .result (calc_s)
    );

    // Control FSM, latency counter, staging and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            hi_n_r  <= 32'd0;
            lo_n_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (op_s)
                            MDU_MULT, MDU_MULTU: begin
                                {hi_n_r, lo_n_r} <= calc_s;
                                cnt_r            <= MULT_LOAD;
                                busy_r           <= 1'b1;
                                state_r          <= ST_BUSY;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                {hi_n_r, lo_n_r} <= calc_s;
                                cnt_r            <= DIV_LOAD;
                                busy_r           <= 1'b1;
                                state_r          <= ST_BUSY;
                            end
                            MDU_MTHI: hi_r <= bus.D1;
                            MDU_MTLO: lo_r <= bus.D1;
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Requests arriving while busy are dropped; only the countdown advances.
                    if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        hi_r    <= hi_n_r;
                        lo_r    <= lo_n_r;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected commits are queued at issue time and
// checked by a monitor on every busy falling edge.
module tb_mdu_hilo;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;
    exp_t sb_q[$];

    mdu_hilo_if bus ();

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ehi, input logic [31:0] elo, input int cyc, input string name);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cyc = cyc; e.name = name;
        sb_q.push_back(e);
    endtask

    // Drive one request for a single cycle; returns 2 time units after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.MDUop = op; bus.D1 = a; bus.D2 = b;
        @(posedge clk);
        #2;
        bus.start = 1'b0; bus.MDUop = 3'b000;
    endtask

    task automatic wait_idle(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL %s_timeout: busy still %0b after 40 cycles, expected 0", name, bus.busy);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int cyc, input string name);
        push(ehi, elo, cyc, name);
        issue(op, a, b);
        wait_idle(name);
    endtask

    // Monitor: measures each busy pulse and checks the committed HI/LO against the queue head
    initial begin
        logic prev;
        int   bc;
        exp_t e;
        prev = 1'b0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                bc   = 0;
            end else if (bus.busy) begin
                bc++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_commit: hi=%08h lo=%08h with no pending op", bus.hi, bus.lo);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_busy_cycles"}, 32'(bc), 32'(e.cyc));
                    chk({e.name, "_hi"}, bus.hi, e.hi);
                    chk({e.name, "_lo"}, bus.lo, e.lo);
                end
                bc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.MDUop = 3'b000; bus.D1 = 32'd0; bus.D2 = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);

        run_op(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  "mult_m1x2");
        #1;
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5,  "multu_max_x2");
        #1;
        run_op(MDU_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, "mult_2p16sq");
        #1;
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_m7_2");
        #1;
        run_op(MDU_DIV,   32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_7_m2");
        #1;
        run_op(MDU_DIVU,  32'd7, 32'd2, 32'h0000_0001, 32'h0000_0003, 10, "divu_7_2");
        #1;
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div_ovf");
        #1;
        run_op(MDU_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, "div_m5_by0");
        #1;
        run_op(MDU_DIVU,  32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 10, "divu_5_by0");

        // mthi/mtlo take effect on the accepting edge without raising busy
        #1;
        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_lo_kept", bus.lo, 32'hFFFF_FFFF);
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", bus.lo, 32'hCAFE_F00D);
        chk("mtlo_hi_kept", bus.hi, 32'h1234_5678);

        // mtlo issued while a mult is in flight must be dropped
        push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_then_mtlo");
        issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        @(posedge clk); #2;
        issue(MDU_MTLO, 32'hDEAD_BEEF, 32'd0);
        chk("busy_hold_lo", bus.lo, 32'hCAFE_F00D);
        chk("busy_hold_hi", bus.hi, 32'h1234_5678);
        wait_idle("mult_then_mtlo");

        // Asynchronous reset in the third busy cycle of a divide
        #1;
        issue(MDU_DIV, 32'd100, 32'd7);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        sb_q.delete();
        reset = 1'b1;
        #1;
        chk("async_reset_hi", bus.hi, 32'd0);
        chk("async_reset_lo", bus.lo, 32'd0);
        chk("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("no_commit_hi", bus.hi, 32'd0);
        chk("no_commit_lo", bus.lo, 32'd0);

        // Back-to-back: second mult accepted in the first idle cycle
        run_op(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 5, "mult_6x7");
        #1;
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'h0000_000F, 5, "b2b_mult_m3xm5");
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
